// File: rtl/fifo_frame_reader.sv
// Read-side controller for a show-ahead FIFO. Pops samples and re-emits them as framed
// valid/ready streams (m_tlast on the final sample) through a 2-entry output skid buffer.
module fifo_frame_reader #(
   parameter int unsigned DATA_WIDTH = 31,
   parameter int unsigned FRAME_LEN  = 1024,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  start,
   input  logic                  cont_mode,
   input  logic                  abort,
   input  logic                  rd_vld,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tlast,
   output logic                  busy,
   output logic                  frame_done,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [CNT_WIDTH-1:0]  underrun_cnt
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   localparam logic [CNT_WIDTH-1:0] LastIdx = CNT_WIDTH'(FRAME_LEN - 1);
   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

   state_e                state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] spare_q, spare_d;
   logic [CNT_WIDTH-1:0]  rd_idx_q, rd_idx_d;
   logic [CNT_WIDTH-1:0]  out_idx_q, out_idx_d;
   logic                  frame_done_q;
   logic [CNT_WIDTH-1:0]  frame_cnt_q;
   logic [CNT_WIDTH-1:0]  underrun_q;

   logic push;
   logic pop;
   logic last_hs;

   // occ_q is registered, so rd_en never sees m_tready combinationally
   assign rd_en    = (state_q == StRun) && rd_vld && (occ_q < 2'd2) && !abort;
   assign push     = rd_en;
   assign m_tvalid = (occ_q != 2'd0);
   assign pop      = m_tvalid && m_tready;
   assign m_tdata  = head_q;
   assign m_tlast  = m_tvalid && (out_idx_q == LastIdx);
   assign last_hs  = pop && (out_idx_q == LastIdx);

   assign busy         = (state_q != StIdle);
   assign frame_done   = frame_done_q;
   assign frame_cnt    = frame_cnt_q;
   assign underrun_cnt = underrun_q;

   always_comb begin
      state_d   = state_q;
      rd_idx_d  = rd_idx_q;
      out_idx_d = out_idx_q;
      if (push) rd_idx_d = rd_idx_q + CntOne;
      if (pop) out_idx_d = out_idx_q + CntOne;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               rd_idx_d  = '0;
               out_idx_d = '0;
            end
         end
         StRun: begin
            if (push && (rd_idx_q == LastIdx)) state_d = StDrain;
         end
         StDrain: begin
            if (last_hs) begin
               state_d   = cont_mode ? StRun : StIdle;
               rd_idx_d  = '0;
               out_idx_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
      if (abort) begin
         state_d   = StIdle;
         rd_idx_d  = '0;
         out_idx_d = '0;
      end
   end

   // Skid buffer: head drives the output, spare catches a push while the head is stalled
   always_comb begin
      occ_d   = occ_q;
      head_d  = head_q;
      spare_d = spare_q;
      unique case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) head_d = rd_data;
            else spare_d = rd_data;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = spare_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: head_d = rd_data;  // push needs occ<2 and pop needs occ>0, so occ==1 here
         default: ;
      endcase
      if (abort) occ_d = 2'd0;
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q      <= StIdle;
         occ_q        <= 2'd0;
         head_q       <= '0;
         spare_q      <= '0;
         rd_idx_q     <= '0;
         out_idx_q    <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         underrun_q   <= '0;
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         head_q       <= head_d;
         spare_q      <= spare_d;
         rd_idx_q     <= rd_idx_d;
         out_idx_q    <= out_idx_d;
         frame_done_q <= last_hs && !abort;
         if (last_hs && !abort) frame_cnt_q <= frame_cnt_q + CntOne;
         if ((state_q == StRun) && !rd_vld && (underrun_q != '1)) begin
            underrun_q <= underrun_q + CntOne;
         end
      end
   end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Randomized bench for fifo_frame_reader: a queue-based FIFO/stream model checks every cycle.
module tb_fifo_frame_reader;

   localparam int DW = 31;
   localparam int FL = 8;
   localparam int CW = 16;

   logic          rd_clk = 1'b0;
   logic          rd_rst_n;
   logic          start, cont_mode, abort, rd_vld, m_tready;
   logic [DW-1:0] rd_data, m_tdata;
   logic          rd_en, m_tvalid, m_tlast, busy, frame_done;
   logic [CW-1:0] frame_cnt, underrun_cnt;

   always #5 rd_clk = ~rd_clk;

   fifo_frame_reader #(
      .DATA_WIDTH(DW),
      .FRAME_LEN (FL),
      .CNT_WIDTH (CW)
   ) dut (
      .rd_clk      (rd_clk),
      .rd_rst_n    (rd_rst_n),
      .start       (start),
      .cont_mode   (cont_mode),
      .abort       (abort),
      .rd_vld      (rd_vld),
      .rd_data     (rd_data),
      .rd_en       (rd_en),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tdata     (m_tdata),
      .m_tlast     (m_tlast),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_cnt   (frame_cnt),
      .underrun_cnt(underrun_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // FIFO contents, popped-but-not-delivered words, and the delivered stream
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] pend_q[$];
   logic [DW-1:0] out_log[$];
   bit            tl_log[$];

   bit m_busy = 0;
   int m_reads = 0, m_beat = 0, m_fcnt = 0, m_ucnt = 0;
   bit m_done = 0;

   bit nx_start = 0, nx_abort = 0, nx_cont = 0;
   int ready_mode = 0;
   bit vld_rand = 0;
   int gap_after = -1, gap_left = 0, scen_pops = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic load(input int base, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
   endtask

   task automatic model_reset();
      pend_q.delete();
      m_busy = 0;
      m_reads = 0;
      m_beat = 0;
      m_fcnt = 0;
      m_ucnt = 0;
      m_done = 0;
   endtask

   task automatic step();
      bit exp_valid, exp_rd_en, hs, was_busy, in_run, vld_ok;
      @(negedge rd_clk);
      start     = nx_start;
      abort     = nx_abort;
      cont_mode = nx_cont;
      nx_start  = 0;
      nx_abort  = 0;
      case (ready_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = (cyc % 3 == 0);
         2:       m_tready = 1'($urandom_range(0, 1));
         default: m_tready = (out_log.size() < 4);
      endcase
      vld_ok = fifo_q.size() > 0;
      if (vld_rand && $urandom_range(0, 3) == 0) vld_ok = 0;
      if (gap_left > 0 && scen_pops == gap_after) begin
         vld_ok = 0;
         gap_left--;
      end
      rd_vld  = vld_ok;
      rd_data = vld_ok ? fifo_q[0] : DW'($urandom);
      cyc++;
      #1;
      exp_valid = pend_q.size() > 0;
      in_run    = m_busy && (m_reads < FL);
      exp_rd_en = in_run && rd_vld && (pend_q.size() < 2) && !abort;
      chk("rd_en", rd_en, exp_rd_en);
      chk("m_tvalid", m_tvalid, exp_valid);
      if (exp_valid) begin
         chk("m_tdata", m_tdata, pend_q[0]);
         chk("m_tlast", m_tlast, m_beat == FL - 1);
      end else begin
         chk("m_tlast_idle", m_tlast, 0);
      end
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, m_done);
      chk("frame_cnt", frame_cnt, m_fcnt % 65536);
      chk("underrun_cnt", underrun_cnt, m_ucnt);

      // Advance the model across the coming clock edge
      hs       = exp_valid && m_tready;
      was_busy = m_busy;
      m_done   = 0;
      if (in_run && !rd_vld && m_ucnt < 65535) m_ucnt++;
      if (abort) begin
         pend_q.delete();
         m_busy  = 0;
         m_reads = 0;
         m_beat  = 0;
      end else begin
         if (hs) begin
            out_log.push_back(pend_q.pop_front());
            tl_log.push_back(m_beat == FL - 1);
            if (m_beat == FL - 1) begin
               m_beat = 0;
               m_done = 1;
               m_fcnt++;
               if (cont_mode) m_reads = 0;
               else m_busy = 0;
            end else begin
               m_beat++;
            end
         end
         if (exp_rd_en) begin
            pend_q.push_back(fifo_q.pop_front());
            m_reads++;
            scen_pops++;
         end
         if (!was_busy && start) begin
            m_busy  = 1;
            m_reads = 0;
            m_beat  = 0;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic new_scenario();
      out_log.delete();
      tl_log.delete();
      scen_pops = 0;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_m_tvalid"}, m_tvalid, 0);
      chk({tag, "_m_tdata"}, m_tdata, 0);
      chk({tag, "_m_tlast"}, m_tlast, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_frame_cnt"}, frame_cnt, 0);
      chk({tag, "_underrun_cnt"}, underrun_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      logic [DW-1:0] first_word;
      rd_rst_n  = 1'b0;
      start     = 0;
      cont_mode = 0;
      abort     = 0;
      rd_vld    = 0;
      rd_data   = '0;
      m_tready  = 0;
      #2;
      check_zero_outputs("reset");
      #10 rd_rst_n = 1'b1;
      run(3);

      // 1: basic frame
      new_scenario();
      load(32'h10, 8);
      nx_start = 1;
      step();
      step();
      chk("s1_no_valid_cycle1", m_tvalid, 0);
      step();
      chk("s1_first_valid_cycle2", m_tvalid, 1);
      run(20);
      chk("s1_count", out_log.size(), 8);
      for (int i = 0; i < out_log.size() && i < 8; i++) chk("s1_data", out_log[i], 32'h10 + i);
      chk("s1_tlast_7", tl_log[7], 1);
      chk("s1_tlast_6", tl_log[6], 0);
      chk("s1_frame_cnt", frame_cnt, 1);
      chk("s1_busy", busy, 0);

      // 2: backpressure 1,0,0
      new_scenario();
      load(32'h10, 8);
      ready_mode = 1;
      nx_start = 1;
      run(45);
      chk("s2_count", out_log.size(), 8);
      for (int i = 0; i < out_log.size() && i < 8; i++) chk("s2_data", out_log[i], 32'h10 + i);
      chk("s2_frame_cnt", frame_cnt, 2);

      // 3: underrun gap of 5 after 3rd pop
      new_scenario();
      load(32'h20, 8);
      ready_mode = 0;
      gap_after = 3;
      gap_left = 5;
      nx_start = 1;
      run(30);
      chk("s3_underrun", underrun_cnt, 5);
      chk("s3_count", out_log.size(), 8);
      for (int i = 0; i < out_log.size() && i < 8; i++) chk("s3_data", out_log[i], 32'h20 + i);
      chk("s3_tlast_7", tl_log[7], 1);
      chk("s3_frame_cnt", frame_cnt, 3);
      gap_after = -1;

      // 4: continuous mode, random ready and valid
      new_scenario();
      load(0, 24);
      ready_mode = 2;
      vld_rand = 1;
      nx_cont = 1;
      nx_start = 1;
      for (int i = 0; i < 400; i++) begin
         step();
         if (out_log.size() >= 18) nx_cont = 0;
         if (!nx_cont && !busy && out_log.size() >= 24) break;
      end
      vld_rand = 0;
      chk("s4_count", out_log.size(), 24);
      for (int i = 0; i < out_log.size() && i < 24; i++) begin
         chk("s4_data", out_log[i], i);
         chk("s4_tlast", tl_log[i], (i % 8) == 7);
      end
      chk("s4_frame_cnt", frame_cnt, 6);
      chk("s4_busy", busy, 0);

      // 5: abort with skid full after 4 beats
      new_scenario();
      load(32'h40, 16);
      ready_mode = 3;
      nx_start = 1;
      guard = 0;
      while (!(pend_q.size() == 2 && out_log.size() >= 4) && guard < 40) begin
         step();
         guard++;
      end
      n_tests++;
      if (guard >= 40) begin
         n_fail++;
         $display("FAIL s5_setup: got timeout, expected skid full after 4 beats");
      end
      nx_abort = 1;
      step();
      chk("s5_abort_rd_en", rd_en, 0);
      chk("s5_stalled_valid", m_tvalid, 1);
      step();
      chk("s5_valid_drop", m_tvalid, 0);
      chk("s5_busy", busy, 0);
      chk("s5_frame_cnt", frame_cnt, 6);
      chk("s5_no_done", frame_done, 0);
      new_scenario();
      ready_mode = 0;
      nx_start = 1;
      run(25);
      chk("s5_restart_first", out_log[0], 32'h46);
      chk("s5_restart_count", out_log.size(), 8);
      chk("s5_frame_cnt_after", frame_cnt, 7);

      // 6: asynchronous reset mid-frame
      new_scenario();
      fifo_q.delete();
      load(32'h50, 16);
      nx_start = 1;
      run(5);
      #1 rd_rst_n = 1'b0;
      #1;
      check_zero_outputs("s6_async");
      model_reset();
      #10 rd_rst_n = 1'b1;
      new_scenario();
      first_word = fifo_q[0];
      nx_start = 1;
      run(25);
      chk("s6_count", out_log.size(), 8);
      chk("s6_first", out_log[0], first_word);
      chk("s6_frame_cnt", frame_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
